// File: rtl/core_run_ctrl_pkg.sv
// Shared types and constants for the core run-control sequencer.
package core_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] CAUSE_HALTREQ = 2'b00;
    localparam logic [1:0] CAUSE_HATA    = 2'b01;
    localparam logic [1:0] CAUSE_STEPLIM = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/core_run_controller_fetch_timeout_ctr.sv
// Fetch watchdog: counts cycles spent in FETCH and flags the last allowed cycle.
// Only instantiated when CORE_RUN_CTRL_TIMEOUT_EN is defined.
module fetch_timeout_ctr
    import core_run_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    output logic tc
);
    localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cleared on the way into FETCH so the entry cycle reads zero; stops at terminal count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (active && !tc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // High during the TIMEOUT_CYCLES-th FETCH cycle.
    assign tc = active && (cnt_q == TC_VAL);

endmodule

// File: rtl/core_run_controller.sv
// Run-control sequencer: fetches one instruction at the core's PC, latches it,
// gives the core a one-cycle commit enable and counts retirements.
// Optional fetch timeout halt is enabled with the macro CORE_RUN_CTRL_TIMEOUT_EN.
module core_run_controller
    import core_run_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int STEP_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [STEP_W-1:0] step_limit,
    input  logic [31:0]       pc_core,
    input  logic              hata_core,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       komut_core,
    output logic              core_en,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [STEP_W-1:0] retired
);

    ctrl_state_t       state_q, state_d;
    logic              fetch_first_q;
    logic              fetch_enter;
    logic [31:0]       addr_q;
    logic [31:0]       komut_q;
    logic [STEP_W-1:0] retired_q;
    logic [STEP_W-1:0] step_lim_q;
    logic [1:0]        cause_q, cause_d;
    logic              halt_flag_q;
    logic              start_run;
    logic              retire_inc;
    logic              timeout_tc;
    logic              limit_hit;

    // Retire counter sticks at all-ones instead of wrapping.
    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (&v) ? v : v + STEP_W'(1);
    endfunction

    assign limit_hit = (step_lim_q != '0) &&
                       (({1'b0, retired_q} + (STEP_W+1)'(1)) == {1'b0, step_lim_q});

`ifdef CORE_RUN_CTRL_TIMEOUT_EN
    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (fetch_enter),
        .active (state_q == ST_FETCH),
        .tc     (timeout_tc)
    );
`else
    assign timeout_tc = 1'b0;
`endif

    // Next-state and control outputs; EXEC exit checks error, then halt request, then step limit.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        start_run  = 1'b0;
        retire_inc = 1'b0;
        imem_req   = 1'b0;
        core_en    = 1'b0;
        running    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    start_run = 1'b1;
                end
            end
            ST_FETCH: begin
                running  = 1'b1;
                imem_req = 1'b1;
                if (imem_valid) begin
                    state_d = ST_EXEC;
                end else if (timeout_tc) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC: begin
                running = 1'b1;
                core_en = 1'b1;
                if (hata_core) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_HATA;
                end else begin
                    retire_inc = 1'b1;
                    if (halt_flag_q || halt_req) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_HALTREQ;
                    end else if (limit_hit) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_STEPLIM;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_d   = ST_FETCH;
                    start_run = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fetch_enter = (state_q != ST_FETCH) && (state_d == ST_FETCH);

    // State register and first-FETCH-cycle marker.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fetch_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_first_q <= fetch_enter;
        end
    end

    // Address/instruction latches, retire counter, cause and sticky halt flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= '0;
            komut_q     <= '0;
            retired_q   <= '0;
            step_lim_q  <= '0;
            cause_q     <= '0;
            halt_flag_q <= 1'b0;
        end else begin
            // The core's PC settles at the edge that ends EXEC, so capture it one cycle later.
            if (fetch_first_q) begin
                addr_q <= pc_core;
            end
            if (state_q == ST_FETCH && imem_valid) begin
                komut_q <= imem_rdata;
            end
            if (start_run) begin
                retired_q   <= '0;
                cause_q     <= CAUSE_HALTREQ;
                halt_flag_q <= 1'b0;
                step_lim_q  <= step_limit;
            end else begin
                cause_q <= cause_d;
                if (retire_inc) begin
                    retired_q <= sat_inc(retired_q);
                end
                if (running && halt_req) begin
                    halt_flag_q <= 1'b1;
                end
            end
        end
    end

    assign imem_addr  = fetch_first_q ? pc_core : addr_q;
    assign komut_core = komut_q;
    assign halt_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Scoreboard bench for core_run_controller: instruction-level reference model,
// memory/core environment models and a decoupled output monitor.
module tb_core_run_controller;
    import core_run_ctrl_pkg::*;

    localparam int STEP_W = 16;
    localparam int TO_CYC = 8;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              halt_req = 1'b0;
    logic [STEP_W-1:0] step_limit = '0;
    logic [31:0]       pc_core = 32'h0000_1000;
    logic              hata_core = 1'b0;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_valid = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic [31:0]       komut_core;
    logic              core_en;
    logic              running;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [STEP_W-1:0] retired;

    core_run_controller #(
        .TIMEOUT_CYCLES (TO_CYC),
        .STEP_W         (STEP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt_req   (halt_req),
        .step_limit (step_limit),
        .pc_core    (pc_core),
        .hata_core  (hata_core),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .komut_core (komut_core),
        .core_en    (core_en),
        .running    (running),
        .halted     (halted),
        .halt_cause (halt_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_halt;
        logic [31:0]       pc;
        logic [31:0]       word;
        int                nfetch;
        logic [1:0]        cause;
        logic [STEP_W-1:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   lat_s[$];
    bit   hata_s[$];
    bit   hreq_s[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Core model: PC advances by one word on each commit.
    always @(posedge clk) begin
        if (core_en) pc_core <= pc_core + 32'd4;
    end

    // Memory / core-error environment, driven just after each active edge.
    int          fetch_idx = 0;
    int          commit_idx = 0;
    int          wait_cnt = 0;
    bit          prev_running = 1'b0;
    bit          force_valid = 1'b0;
    logic [31:0] served_addr = '0;

    always @(posedge clk) begin
        int lat;
        #1;
        halt_req   = 1'b0;
        hata_core  = 1'b0;
        imem_valid = 1'b0;
        if (!reset) begin
            fetch_idx  = 0;
            commit_idx = 0;
            wait_cnt   = 0;
        end else begin
            if (start && !prev_running) begin
                fetch_idx  = 0;
                commit_idx = 0;
                wait_cnt   = 0;
            end
            if (imem_req) begin
                lat = (fetch_idx < lat_s.size()) ? lat_s[fetch_idx] : 1;
                if (wait_cnt == 0 && fetch_idx < hreq_s.size() && hreq_s[fetch_idx]) halt_req = 1'b1;
                if (wait_cnt == lat) begin
                    imem_valid  = 1'b1;
                    imem_rdata  = word_of(imem_addr);
                    served_addr = imem_addr;
                end
                wait_cnt++;
            end else begin
                if (wait_cnt != 0) fetch_idx++;
                wait_cnt = 0;
            end
            if (core_en) begin
                if (commit_idx < hata_s.size()) hata_core = hata_s[commit_idx];
                commit_idx++;
            end
        end
        if (force_valid) begin
            imem_valid = 1'b1;
            imem_rdata = $urandom;
        end
        prev_running = running;
    end

    // Monitor: pops an expectation on every commit pulse and every entry into HALT.
    int req_cnt = 0;
    bit prev_en = 1'b0;
    bit prev_halted = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            req_cnt     = 0;
            prev_en     = 1'b0;
            prev_halted = 1'b0;
        end else begin
            if (imem_req) req_cnt++;
            if (core_en) begin
                chk("core_en_single_cycle", 64'(prev_en), 64'(0));
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_commit: actual=commit required=none komut=0x%0h", komut_core);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_kind", 64'(e.is_halt), 64'(0));
                    chk("commit_addr", 64'(served_addr), 64'(e.pc));
                    chk("commit_komut", 64'(komut_core), 64'(e.word));
                    chk("commit_fetch_cycles", 64'(req_cnt), 64'(e.nfetch));
                end
                req_cnt = 0;
            end
            if (halted && !prev_halted) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_halt: actual=halt cause=%0d required=none", halt_cause);
                end else begin
                    e = exp_q.pop_front();
                    chk("halt_kind", 64'(e.is_halt), 64'(1));
                    chk("halt_cause", 64'(halt_cause), 64'(e.cause));
                    chk("halt_retired", 64'(retired), 64'(e.ret));
                    chk("halt_req_dropped", 64'(imem_req), 64'(0));
                    if (e.cause == CAUSE_TIMEOUT) chk("timeout_fetch_cycles", 64'(req_cnt), 64'(e.nfetch));
                end
                req_cnt = 0;
            end
            prev_en     = core_en;
            prev_halted = halted;
        end
    end

    // Reference model: walks the per-instruction script and predicts commits and the halt.
    task automatic plan_run(input logic [STEP_W-1:0] lim);
        logic [31:0] pc;
        exp_t        e;
        pc = pc_core;
        for (int k = 0; k < lat_s.size(); k++) begin
            if (TO_EN && lat_s[k] >= TO_CYC) begin
                e = '{is_halt: 1'b1, pc: '0, word: '0, nfetch: TO_CYC, cause: CAUSE_TIMEOUT, ret: STEP_W'(k)};
                exp_q.push_back(e);
                return;
            end
            e = '{is_halt: 1'b0, pc: pc + 32'(4 * k), word: word_of(pc + 32'(4 * k)),
                  nfetch: lat_s[k] + 1, cause: '0, ret: '0};
            exp_q.push_back(e);
            e = '{is_halt: 1'b1, pc: '0, word: '0, nfetch: 0, cause: '0, ret: '0};
            if (hata_s[k]) begin
                e.cause = CAUSE_HATA;
                e.ret   = STEP_W'(k);
                exp_q.push_back(e);
                return;
            end
            if (hreq_s[k]) begin
                e.cause = CAUSE_HALTREQ;
                e.ret   = STEP_W'(k + 1);
                exp_q.push_back(e);
                return;
            end
            if (lim != '0 && STEP_W'(k + 1) == lim) begin
                e.cause = CAUSE_STEPLIM;
                e.ret   = STEP_W'(k + 1);
                exp_q.push_back(e);
                return;
            end
        end
    endtask

    task automatic clear_script();
        lat_s.delete();
        hata_s.delete();
        hreq_s.delete();
    endtask

    task automatic add_instr(input int lat, input bit h, input bit r);
        lat_s.push_back(lat);
        hata_s.push_back(h);
        hreq_s.push_back(r);
    endtask

    task automatic fill_random(input bit zero_wait);
        clear_script();
        for (int k = 0; k < 12; k++) begin
            add_instr(zero_wait ? 0 : int'($urandom_range(0, 3)),
                      $urandom_range(0, 9) == 0,
                      ($urandom_range(0, 6) == 0) || (k == 11));
        end
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!(halted && exp_q.size() == 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            chk("run_completes", 64'(0), 64'(1));
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_run(input logic [STEP_W-1:0] lim, input bit poke_start);
        logic [31:0] pc_at_start;
        plan_run(lim);
        @(negedge clk);
        step_limit = lim;
        start      = 1'b1;
        pc_at_start = pc_core;
        @(negedge clk);
        start = 1'b0;
        chk("start_retired_cleared", 64'(retired), 64'(0));
        chk("start_req_next_cycle", 64'(imem_req), 64'(1));
        chk("start_fetch_addr", 64'(imem_addr), 64'(pc_at_start));
        if (poke_start) begin
            @(negedge clk);
            if (running) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_done();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl_zero"}, 64'({imem_req, core_en, running, halted, halt_cause, retired}), 64'(0));
        chk({tag, "_data_zero"}, {komut_core, imem_addr}, 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run: three instructions, two-cycle memory latency, step limit 3.
        clear_script();
        for (int k = 0; k < 3; k++) add_instr(2, 1'b0, 1'b0);
        do_run(16'd3, 1'b0);

        // Halt request during the second fetch.
        clear_script();
        add_instr(1, 1'b0, 1'b0);
        add_instr(1, 1'b0, 1'b1);
        do_run(16'd0, 1'b0);

        // Error beats a pending halt request.
        clear_script();
        add_instr(1, 1'b1, 1'b1);
        do_run(16'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hata_no_more_req", 64'(imem_req), 64'(0));

        // Zero-wait memory, then restart from HALT.
        clear_script();
        for (int k = 0; k < 4; k++) add_instr(0, 1'b0, 1'b0);
        do_run(16'd4, 1'b0);
        do_run(16'd4, 1'b0);

        // Reset while a fetch is outstanding, followed by a late imem_valid.
        clear_script();
        add_instr(1000, 1'b0, 1'b0);
        @(negedge clk);
        step_limit = 16'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_req", 64'(imem_req), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        reset       = 1'b1;
        force_valid = 1'b1;
        check_all_zero("midfetch_reset");
        repeat (3) begin
            @(negedge clk);
            check_all_zero("late_valid");
        end
        force_valid = 1'b0;
        @(negedge clk);

`ifdef CORE_RUN_CTRL_TIMEOUT_EN
        // Memory never answers: timeout halt after TO_CYC fetch cycles.
        clear_script();
        add_instr(1000, 1'b0, 1'b0);
        do_run(16'd0, 1'b0);
        // Answer arrives in the terminal-count cycle and is accepted.
        clear_script();
        add_instr(TO_CYC - 1, 1'b0, 1'b0);
        do_run(16'd1, 1'b0);
`endif

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            fill_random($urandom_range(0, 3) == 0);
            do_run(STEP_W'($urandom_range(0, 6)), $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
